// File: rtl/direct_mapped_cache.sv
`default_nettype none
// ============================================================================
// Module      : direct_mapped_cache
// Description : Byte-addressed direct-mapped, write-allocate cache with no
//               backing store. Define DMC_PERF_COUNTERS_EN for hit/miss
//               counters.
// Revision    : 1.0 - initial release
// ============================================================================
module direct_mapped_cache #(
    parameter int CACHE_SIZE = 256,
    parameter int BLOCK_SIZE = 16,
    parameter int ASSOC      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [7:0]  wr_data,
    input  logic        wr_en,
    output logic [7:0]  rd_data,
    output logic        hit,
    output logic        miss
`ifdef DMC_PERF_COUNTERS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int NUM_SETS = CACHE_SIZE / (BLOCK_SIZE * ASSOC);
    localparam int OFFSET_W = $clog2(BLOCK_SIZE);
    localparam int INDEX_W  = $clog2(NUM_SETS);
    localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;
    // Zero-width fields still need a 1-bit carrier signal.
    localparam int c_idx_w  = (INDEX_W  > 0) ? INDEX_W  : 1;
    localparam int c_off_w  = (OFFSET_W > 0) ? OFFSET_W : 1;

    generate
        if (ASSOC != 1) begin : g_bad_assoc
            $error("direct_mapped_cache: ASSOC must be 1");
        end
    endgenerate

    logic [c_idx_w-1:0] w_index;
    logic [c_off_w-1:0] w_offset;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;

    generate
        if (INDEX_W > 0) begin : g_index
            assign w_index = addr[OFFSET_W+INDEX_W-1:OFFSET_W];
        end else begin : g_no_index
            assign w_index = '0;
        end
        if (OFFSET_W > 0) begin : g_offset
            assign w_offset = addr[OFFSET_W-1:0];
        end else begin : g_no_offset
            assign w_offset = '0;
        end
    endgenerate

    assign w_tag = addr[31:OFFSET_W+INDEX_W];

    logic [NUM_SETS-1:0] r_valid;
    logic [TAG_W-1:0]    r_tag  [NUM_SETS];
    logic [7:0]          r_data [NUM_SETS][BLOCK_SIZE];
    logic                r_hit;
    logic                r_miss;
    logic [7:0]          r_rd_data;

    assign w_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= '0;
            r_hit     <= 1'b0;
            r_miss    <= 1'b0;
            r_rd_data <= 8'h00;
        end else begin
            r_hit  <= w_hit;
            r_miss <= ~w_hit;
            if (!w_hit) begin
                r_valid[w_index] <= 1'b1;
            end
            if (wr_en) begin
                r_rd_data <= wr_data;
            end else if (w_hit) begin
                r_rd_data <= r_data[w_index][w_offset];
            end else begin
                r_rd_data <= 8'h00;
            end
        end
    end

    // Line storage is not reset; valid bits alone qualify its contents.
    // The byte write follows the fill so a write-miss lands on a cleared line.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (!w_hit) begin
                r_tag[w_index] <= w_tag;
                for (int b = 0; b < BLOCK_SIZE; b++) begin
                    r_data[w_index][b] <= 8'h00;
                end
            end
            if (wr_en) begin
                r_data[w_index][w_offset] <= wr_data;
            end
        end
    end

    assign hit     = r_hit;
    assign miss    = r_miss;
    assign rd_data = r_rd_data;

`ifdef DMC_PERF_COUNTERS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else if (w_hit) begin
            r_hit_count  <= r_hit_count + 32'd1;
        end else begin
            r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_direct_mapped_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_direct_mapped_cache
// Description : Directed plus random checks of direct_mapped_cache against an
//               arithmetic line model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_direct_mapped_cache;

    localparam int CACHE_SIZE = 256;
    localparam int BLOCK_SIZE = 16;
    localparam int NUM_SETS   = CACHE_SIZE / BLOCK_SIZE;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_en = 1'b0;
    logic [7:0]  rd_data;
    logic        hit;
    logic        miss;
`ifdef DMC_PERF_COUNTERS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    direct_mapped_cache #(
        .CACHE_SIZE (CACHE_SIZE),
        .BLOCK_SIZE (BLOCK_SIZE),
        .ASSOC      (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .rd_data    (rd_data),
        .hit        (hit),
        .miss       (miss)
`ifdef DMC_PERF_COUNTERS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: line = (addr / BLOCK_SIZE) mod sets, tag = addr / CACHE_SIZE.
    bit          m_valid [NUM_SETS];
    int unsigned m_tag   [NUM_SETS];
    bit [7:0]    m_data  [NUM_SETS][BLOCK_SIZE];
    int unsigned m_hits  = 0;
    int unsigned m_misses = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int s = 0; s < NUM_SETS; s++) m_valid[s] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
        check("reset_hit", {31'd0, hit}, 32'd0);
        check("reset_miss", {31'd0, miss}, 32'd0);
        check("reset_rd_data", {24'd0, rd_data}, 32'd0);
`ifdef DMC_PERF_COUNTERS_EN
        check("reset_hit_count", hit_count, 32'd0);
        check("reset_miss_count", miss_count, 32'd0);
`endif
    endtask

    task automatic access(input logic [31:0] a, input logic [7:0] d, input logic w);
        int unsigned set, off, tg;
        bit          h;
        logic [7:0]  exp_rd;
        addr    = a;
        wr_data = d;
        wr_en   = w;
        set = (a / BLOCK_SIZE) % NUM_SETS;
        off = a % BLOCK_SIZE;
        tg  = a / CACHE_SIZE;
        h   = m_valid[set] && (m_tag[set] == tg);
        if (h) begin
            m_hits++;
        end else begin
            m_misses++;
            m_valid[set] = 1'b1;
            m_tag[set]   = tg;
            for (int b = 0; b < BLOCK_SIZE; b++) m_data[set][b] = 8'h00;
        end
        if (w) m_data[set][off] = d;
        exp_rd = w ? d : (h ? m_data[set][off] : 8'h00);
        @(posedge clk);
        #1;
        check("model_hit", {31'd0, hit}, {31'd0, h});
        check("model_miss", {31'd0, miss}, {31'd0, !h});
        check("model_rd_data", {24'd0, rd_data}, {24'd0, exp_rd});
`ifdef DMC_PERF_COUNTERS_EN
        check("model_hit_count", hit_count, m_hits);
        check("model_miss_count", miss_count, m_misses);
`endif
    endtask

    initial begin
        logic [31:0] a;
        do_reset();

        // Write-then-read on a cold line.
        access(32'h0000_1000, 8'hAA, 1'b1);
        check("wr_first_miss", {31'd0, miss}, 32'd1);
        access(32'h0000_1000, 8'hAA, 1'b1);
        check("wr_second_hit", {31'd0, hit}, 32'd1);
        access(32'h0000_1000, 8'h00, 1'b0);
        check("rd_hit", {31'd0, hit}, 32'd1);
        check("rd_data_aa", {24'd0, rd_data}, 32'h0000_00AA);
`ifdef DMC_PERF_COUNTERS_EN
        check("cnt_hit_2", hit_count, 32'd2);
        check("cnt_miss_1", miss_count, 32'd1);
`endif

        // Conflicting tags on index 0.
        access(32'h0000_2000, 8'hBB, 1'b1);
        check("conflict_wr_miss", {31'd0, miss}, 32'd1);
        access(32'h0000_1000, 8'h00, 1'b0);
        check("conflict_rd_miss", {31'd0, miss}, 32'd1);
        check("conflict_rd_zero", {24'd0, rd_data}, 32'd0);
        access(32'h0000_2000, 8'h00, 1'b0);
        check("conflict_evicted", {31'd0, miss}, 32'd1);

        // Sweep across 32 lines; second half maps onto the same indices.
        for (int i = 0; i < 32; i++) begin
            a = 32'h0001_0000 + 32'(i * 16);
            access(a, 8'h00, 1'b0);
            check("sweep_edge1_miss", {31'd0, miss}, 32'd1);
            access(a, 8'h00, 1'b0);
            check("sweep_edge2_hit", {31'd0, hit}, 32'd1);
        end

        // Every byte offset of one line.
        for (int i = 0; i < 16; i++) access(32'h0005_0000 + 32'(i), 8'(8'hF0 + i), 1'b1);
        for (int i = 0; i < 16; i++) begin
            access(32'h0005_0000 + 32'(i), 8'h00, 1'b0);
            check("offset_hit", {31'd0, hit}, 32'd1);
            check("offset_data", {24'd0, rd_data}, 32'(8'hF0 + i));
        end

        // Reset mid-run discards the line.
        do_reset();
        access(32'h0005_0000, 8'h00, 1'b0);
        check("post_reset_miss", {31'd0, miss}, 32'd1);
        check("post_reset_zero", {24'd0, rd_data}, 32'd0);

        // Random traffic over a few tags so hits and conflicts both occur.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                a = (32'($urandom_range(0, 3)) << 8) | 32'($urandom_range(0, 255));
                if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
                access(a, 8'($urandom), 1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/direct_mapped_cache.md
DIRECT_MAPPED_CACHE -- requirements
Module: direct_mapped_cache

Interface
REQ-001 SHALL have parameter CACHE_SIZE, default 256, total data capacity in bytes.
REQ-002 SHALL have parameter BLOCK_SIZE, default 16, line size in bytes (power of two, >=1).
REQ-003 SHALL have parameter ASSOC, default 1, ways per set; any value other than 1 SHALL be an elaboration error.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-006 SHALL have port addr, input, 32 bits, byte address of the access.
REQ-007 SHALL have port wr_data, input, 8 bits, byte to write.
REQ-008 SHALL have port wr_en, input, 1 bit: 1 means write, 0 means read.
REQ-009 SHALL have port rd_data, output, 8 bits, registered byte result.
REQ-010 SHALL have port hit, output, 1 bit, registered hit flag.
REQ-011 SHALL have port miss, output, 1 bit, registered miss flag.

Function
REQ-012 SHALL derive the geometry as follows: NUM_SETS = CACHE_SIZE/(BLOCK_SIZE*ASSOC); OFFSET_W = clog2(BLOCK_SIZE); INDEX_W = clog2(NUM_SETS); TAG_W = 32-INDEX_W-OFFSET_W.
REQ-013 SHALL split addr as follows: offset = addr[OFFSET_W-1:0]; index = next INDEX_W bits; tag = the upper TAG_W bits.
REQ-014 SHALL store, per set, a valid bit, a TAG_W-bit tag, and BLOCK_SIZE data bytes.
REQ-015 SHALL treat every rising edge with reset low as one access; there is no request-valid or handshake.
REQ-016 SHALL define lookup hit as valid[index] && stored tag == addr tag.
REQ-017 SHALL, on a hit, register hit=1 and miss=0 at that edge.
REQ-018 SHALL, on a miss, register hit=0 and miss=1.
REQ-019 SHALL, on a miss, allocate the line in the same edge: valid=1, tag=addr tag, all BLOCK_SIZE bytes cleared to 0x00. There is no backing memory and no write-back; the previous line is discarded.
REQ-020 SHALL, on a read, register rd_data = stored byte[offset] on a hit, or 0x00 on a miss (the fill value).
REQ-021 SHALL, on a write (hit or miss), write byte[offset] = wr_data after any fill and register rd_data = wr_data. The policy is write-allocate.
REQ-022 SHALL give hit/miss/rd_data a latency of exactly one edge: outputs reflect the access sampled at the most recent rising edge and hold until the next edge.
REQ-023 SHALL keep hit and miss mutually exclusive; exactly one is high after any non-reset edge.
REQ-024 SHALL treat an address held for consecutive edges as repeated accesses: first edge may miss, subsequent edges hit.
REQ-025 SHALL make addresses differing only in tag with equal index evict each other (conflict).

Reset
REQ-026 SHALL, on a reset edge, clear all valid bits and set hit=0, miss=0, rd_data=0x00; tag/data contents are don't-care.
REQ-027 SHALL perform no access or allocation on a reset edge; reset mid-sequence discards all lines.

Configuration
REQ-028 SHALL, when macro DMC_PERF_COUNTERS_EN is defined, add outputs hit_count[31:0] and miss_count[31:0]. These increment on each non-reset edge with a hit or a miss respectively, clear on reset, and wrap at 2^32.
REQ-029 SHALL, without DMC_PERF_COUNTERS_EN, have neither those ports nor the counter logic; all other behaviour is identical.

Verification (defaults: 16 sets, index=addr[7:4], offset=addr[3:0])
REQ-030 SHALL cover write-then-read: after reset, write 0x0000_1000=0xAA. The first edge gives miss=1; the second edge gives hit=1. A subsequent read of 0x0000_1000 gives hit=1, rd_data=0xAA.
REQ-031 SHALL cover conflict: write 0x0000_2000=0xBB (miss), then read 0x0000_1000. The result is miss=1, rd_data=0x00, and 0x0000_2000 is now evicted.
REQ-032 SHALL cover a sequential sweep: read 0x0001_0000..0x0001_01F0 step 16, each address held 2 edges. Each address gives miss on edge 1 and hit on edge 2; the second pass over the same indices misses again.
REQ-033 SHALL cover offsets: write 0x0005_0000+i = 0xF0+i for i=0..15, then read back. All reads give hit=1 with rd_data = 0xF0+i.
REQ-034 SHALL cover reset mid-run: after REQ-033 assert reset for one edge. Outputs become 0. A read of 0x0005_0000 then gives miss=1, rd_data=0x00.
REQ-035 SHALL cover counters: with DMC_PERF_COUNTERS_EN, after REQ-030, hit_count=2 and miss_count=1. After reset both are 0.
